// File: rtl/layer_seq_pkg.sv
// Shared definitions for the layer sequencer and its output bank.
//   state_t         : sequencer state encoding
//   ERR_*_BIT       : bit positions inside the sticky error vector
//   clog2_plus1()   : width of a counter that must hold the value max_val
package layer_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    LOAD_B   = 3'd2,
    STREAM   = 3'd3,
    WAIT_OUT = 3'd4,
    DRAIN    = 3'd5
  } state_t;

  localparam int ERR_SYNC_BIT    = 0;
  localparam int ERR_TIMEOUT_BIT = 1;
  localparam int ERR_W           = 2;

  // Counter width able to represent 0..max_val inclusive (never below 1 bit).
  function automatic int clog2_plus1(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/layer_out_bank.sv
// Output capture bank and serialiser for one layer.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture all NUM_NEURON words of load_data and start draining
//   load_data  : neuron k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_ready  : downstream ready
//   out_data   : registered word for the current index
//   out_valid  : registered valid, held until the word is taken
//   out_last   : registered, high on the word of neuron NUM_NEURON-1
//   xfer_last  : combinational pulse, the last word is being transferred now
module layer_out_bank
  import layer_seq_pkg::*;
#(
  parameter int NUM_NEURON = 30,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] load_data,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  output logic                             out_last,
  output logic                             xfer_last
);

  localparam int IDX_W = clog2_plus1(NUM_NEURON);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURON - 1);

  logic [DATA_WIDTH-1:0] bank_r [NUM_NEURON];
  logic [IDX_W-1:0]      idx_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_valid_r;
  logic                  out_last_r;

  logic [IDX_W-1:0]      idx_nxt_s;
  logic [DATA_WIDTH-1:0] next_word_s;
  logic                  xfer_s;

  // Select the word that follows the current index; a compare mux keeps the
  // counter width independent of the bank depth.
  always_comb begin
    idx_nxt_s   = idx_r + IDX_W'(1);
    next_word_s = '0;
    for (int k = 0; k < NUM_NEURON; k++) begin
      next_word_s = (idx_nxt_s == IDX_W'(k)) ? bank_r[k] : next_word_s;
    end
    xfer_s    = out_valid_r && out_ready;
    xfer_last = xfer_s && out_last_r;
  end

  // Bank capture, index advance and registered ready/valid output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_NEURON; k++) begin
        bank_r[k] <= '0;
      end
      idx_r       <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (load) begin
      for (int k = 0; k < NUM_NEURON; k++) begin
        bank_r[k] <= load_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
      idx_r       <= '0;
      out_data_r  <= load_data[DATA_WIDTH-1:0];
      out_valid_r <= 1'b1;
      out_last_r  <= (NUM_NEURON == 1);
    end else if (xfer_s) begin
      if (idx_r == IDX_LAST) begin
        idx_r       <= '0;
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end else begin
        idx_r      <= idx_nxt_s;
        out_data_r <= next_word_s;
        out_last_r <= (idx_nxt_s == IDX_LAST);
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;

endmodule

// File: rtl/layer_sequencer.sv
// Sequencer for one fully-connected layer of NUM_NEURON neurons.
//   Config: cfg_start/cfg_data/cfg_valid/cfg_ready stream NUM_INPUT weights
//           then one bias per neuron onto n_weight*/n_bias*, tagged with
//           config_layer_num (constant LAYER_NO) and config_neuron_num.
//   Run:    in_data/in_valid/in_ready frame of NUM_INPUT activations is
//           broadcast on n_input*, neuron results n_output/n_output_valid are
//           captured and serialised on out_data/out_valid/out_ready/out_last.
//   Status: busy (not idle), err_sync / err_timeout sticky until rst.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int LAYER_NO   = 0,
  parameter int NUM_NEURON = 30,
  parameter int NUM_INPUT  = 784,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_start,
  input  logic [31:0]                      cfg_data,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_WIDTH-1:0]            n_input,
  output logic                             n_input_valid,
  output logic [31:0]                      n_weight,
  output logic                             n_weight_valid,
  output logic [31:0]                      n_bias,
  output logic                             n_bias_valid,
  output logic [31:0]                      config_layer_num,
  output logic [31:0]                      config_neuron_num,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] n_output,
  input  logic [NUM_NEURON-1:0]            n_output_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             busy,
  output logic                             err_sync,
  output logic                             err_timeout
);

  localparam int W_CNT_W  = clog2_plus1(NUM_INPUT);
  localparam int IN_CNT_W = clog2_plus1(NUM_INPUT);
  localparam int NEU_W    = clog2_plus1(NUM_NEURON);
  localparam int WAIT_W   = clog2_plus1(MAX_WAIT);

  localparam logic [W_CNT_W-1:0]  W_LAST    = W_CNT_W'(NUM_INPUT - 1);
  localparam logic [IN_CNT_W-1:0] IN_LAST   = IN_CNT_W'(NUM_INPUT - 1);
  localparam logic [NEU_W-1:0]    NEU_LAST  = NEU_W'(NUM_NEURON - 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [W_CNT_W-1:0]    w_cnt_r;
  logic [IN_CNT_W-1:0]   in_cnt_r;
  logic [NEU_W-1:0]      neu_cnt_r;
  logic [WAIT_W-1:0]     wait_cnt_r;
  logic [NEU_W-1:0]      cfg_neuron_r;
  logic [DATA_WIDTH-1:0] n_input_r;
  logic                  n_input_valid_r;
  logic [31:0]           n_weight_r;
  logic                  n_weight_valid_r;
  logic [31:0]           n_bias_r;
  logic                  n_bias_valid_r;
  logic [ERR_W-1:0]      err_r;

  logic cfg_ready_s;
  logic in_ready_s;
  logic cfg_acc_s;
  logic in_acc_s;
  logic bank_load_s;
  logic sync_err_s;
  logic timeout_s;
  logic drain_done_s;

  // Next-state decode plus the handshake readies and one-cycle event strobes.
  always_comb begin
    state_nxt_s = state_r;
    cfg_ready_s = 1'b0;
    in_ready_s  = 1'b0;
    bank_load_s = 1'b0;
    sync_err_s  = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // A config request wins over a simultaneous activation.
        if (cfg_start) begin
          state_nxt_s = LOAD_W;
        end else begin
          in_ready_s = 1'b1;
          if (in_valid) begin
            state_nxt_s = (NUM_INPUT == 1) ? WAIT_OUT : STREAM;
          end else begin
            state_nxt_s = IDLE;
          end
        end
      end
      LOAD_W: begin
        cfg_ready_s = 1'b1;
        if (cfg_valid && (w_cnt_r == W_LAST)) begin
          state_nxt_s = LOAD_B;
        end else begin
          state_nxt_s = LOAD_W;
        end
      end
      LOAD_B: begin
        cfg_ready_s = 1'b1;
        if (cfg_valid) begin
          state_nxt_s = (neu_cnt_r == NEU_LAST) ? IDLE : LOAD_W;
        end else begin
          state_nxt_s = LOAD_B;
        end
      end
      STREAM: begin
        in_ready_s = 1'b1;
        if (in_valid && (in_cnt_r == IN_LAST)) begin
          state_nxt_s = WAIT_OUT;
        end else begin
          state_nxt_s = STREAM;
        end
      end
      WAIT_OUT: begin
        if (&n_output_valid) begin
          bank_load_s = 1'b1;
          state_nxt_s = DRAIN;
        end else if (|n_output_valid) begin
          // Neurons disagree; keep the frame moving but flag it.
          bank_load_s = 1'b1;
          sync_err_s  = 1'b1;
          state_nxt_s = DRAIN;
        end else if (wait_cnt_r == WAIT_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_OUT;
        end
      end
      DRAIN: begin
        if (drain_done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    cfg_acc_s = cfg_valid && cfg_ready_s;
    in_acc_s  = in_valid && in_ready_s;
  end

  // State register, counters, registered neuron bus and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      w_cnt_r          <= '0;
      in_cnt_r         <= '0;
      neu_cnt_r        <= '0;
      wait_cnt_r       <= '0;
      cfg_neuron_r     <= '0;
      n_input_r        <= '0;
      n_input_valid_r  <= 1'b0;
      n_weight_r       <= 32'd0;
      n_weight_valid_r <= 1'b0;
      n_bias_r         <= 32'd0;
      n_bias_valid_r   <= 1'b0;
      err_r            <= '0;
    end else begin
      state_r          <= state_nxt_s;
      n_input_valid_r  <= in_acc_s;
      n_weight_valid_r <= cfg_acc_s && (state_r == LOAD_W);
      n_bias_valid_r   <= cfg_acc_s && (state_r == LOAD_B);
      if (in_acc_s) begin
        n_input_r <= in_data;
      end
      if (cfg_acc_s && (state_r == LOAD_W)) begin
        n_weight_r <= cfg_data;
      end
      if (cfg_acc_s && (state_r == LOAD_B)) begin
        n_bias_r <= cfg_data;
      end
      if (cfg_acc_s) begin
        cfg_neuron_r <= neu_cnt_r;
      end
      // The wait counter only runs while waiting; it restarts on every entry.
      if (state_r == WAIT_OUT) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
        wait_cnt_r <= '0;
      end
      case (state_r)
        IDLE: begin
          if (cfg_start) begin
            w_cnt_r   <= '0;
            neu_cnt_r <= '0;
          end else if (in_valid) begin
            in_cnt_r <= IN_CNT_W'(1);
          end
        end
        LOAD_W: begin
          if (cfg_valid) begin
            w_cnt_r <= (w_cnt_r == W_LAST) ? '0 : w_cnt_r + W_CNT_W'(1);
          end
        end
        LOAD_B: begin
          if (cfg_valid) begin
            neu_cnt_r <= (neu_cnt_r == NEU_LAST) ? '0 : neu_cnt_r + NEU_W'(1);
          end
        end
        STREAM: begin
          if (in_valid) begin
            in_cnt_r <= in_cnt_r + IN_CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
      if (sync_err_s) begin
        err_r[ERR_SYNC_BIT] <= 1'b1;
      end
      if (timeout_s) begin
        err_r[ERR_TIMEOUT_BIT] <= 1'b1;
      end
    end
  end

  layer_out_bank #(
    .NUM_NEURON (NUM_NEURON),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_bank (
    .clk       (clk),
    .rst       (rst),
    .load      (bank_load_s),
    .load_data (n_output),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .xfer_last (drain_done_s)
  );

  assign cfg_ready         = cfg_ready_s;
  assign in_ready          = in_ready_s;
  assign n_input           = n_input_r;
  assign n_input_valid     = n_input_valid_r;
  assign n_weight          = n_weight_r;
  assign n_weight_valid    = n_weight_valid_r;
  assign n_bias            = n_bias_r;
  assign n_bias_valid      = n_bias_valid_r;
  assign config_layer_num  = 32'(LAYER_NO);
  assign config_neuron_num = 32'(cfg_neuron_r);
  assign busy              = (state_r != IDLE);
  assign err_sync          = err_r[ERR_SYNC_BIT];
  assign err_timeout       = err_r[ERR_TIMEOUT_BIT];

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: transaction-level expectations
// derived from the config word layout, frame length and drain order.
module tb_layer_sequencer;

  localparam int NN = 3;
  localparam int NI = 4;
  localparam int DW = 16;
  localparam int MW = 8;
  localparam int LN = 5;

  logic              clk;
  logic              rst;
  logic              cfg_start;
  logic [31:0]       cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     n_input;
  logic              n_input_valid;
  logic [31:0]       n_weight;
  logic              n_weight_valid;
  logic [31:0]       n_bias;
  logic              n_bias_valid;
  logic [31:0]       config_layer_num;
  logic [31:0]       config_neuron_num;
  logic [NN*DW-1:0]  n_output;
  logic [NN-1:0]     n_output_valid;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              err_sync;
  logic              err_timeout;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic        exp_err_sync;
  logic        exp_err_timeout;
  logic [31:0] exp_cnn;

  layer_sequencer #(
    .LAYER_NO   (LN),
    .NUM_NEURON (NN),
    .NUM_INPUT  (NI),
    .DATA_WIDTH (DW),
    .MAX_WAIT   (MW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_start         (cfg_start),
    .cfg_data          (cfg_data),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .n_input           (n_input),
    .n_input_valid     (n_input_valid),
    .n_weight          (n_weight),
    .n_weight_valid    (n_weight_valid),
    .n_bias            (n_bias),
    .n_bias_valid      (n_bias_valid),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .n_output          (n_output),
    .n_output_valid    (n_output_valid),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .busy              (busy),
    .err_sync          (err_sync),
    .err_timeout       (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past one rising edge; registered outputs are read 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs react to freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  task automatic chk_reset_state();
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
    chk_eq("rst_out_last", 32'(out_last), 32'd0);
    chk_eq("rst_out_data", 32'(out_data), 32'd0);
    chk_eq("rst_n_input_valid", 32'(n_input_valid), 32'd0);
    chk_eq("rst_n_weight_valid", 32'(n_weight_valid), 32'd0);
    chk_eq("rst_n_bias_valid", 32'(n_bias_valid), 32'd0);
    chk_eq("rst_n_input", 32'(n_input), 32'd0);
    chk_eq("rst_n_weight", n_weight, 32'd0);
    chk_eq("rst_n_bias", n_bias, 32'd0);
    chk_eq("rst_cfg_neuron_num", config_neuron_num, 32'd0);
    chk_eq("rst_cfg_layer_num", config_layer_num, 32'(LN));
    chk_eq("rst_err_sync", 32'(err_sync), 32'd0);
    chk_eq("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk_eq("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk_eq("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic pulse_reset();
    rst            = 1'b1;
    cfg_start      = 1'b0;
    cfg_valid      = 1'b0;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    n_output_valid = '0;
    step();
    rst             = 1'b0;
    exp_err_sync    = 1'b0;
    exp_err_timeout = 1'b0;
    exp_cnn         = 32'd0;
    settle();
    chk_reset_state();
  endtask

  // Config stream: word i belongs to neuron i/(NI+1); the last word of each
  // group of NI+1 is that neuron's bias, the others are weights.
  task automatic do_config(input bit seq_data, input int gap_pct, input bit with_in, input int abort_at);
    int          total;
    int          idx;
    int          guard;
    logic [31:0] word;
    bit          acc;
    bit          is_bias;
    total = NN * (NI + 1);
    idx   = 0;
    guard = 0;
    cfg_start = 1'b1;
    in_valid  = with_in;
    in_data   = 16'h0bad;
    settle();
    chk_eq("in_ready_at_cfg_start", 32'(in_ready), 32'd0);
    step();
    cfg_start = 1'b0;
    in_valid  = 1'b0;
    chk_eq("busy_cfg_entry", 32'(busy), 32'd1);
    chk_eq("no_input_at_cfg_start", 32'(n_input_valid), 32'd0);
    while (idx < total && guard < 1000) begin
      guard++;
      if (idx == abort_at) begin
        pulse_reset();
        return;
      end
      acc  = ($urandom_range(99) >= gap_pct);
      word = seq_data ? 32'(idx + 1) : $urandom;
      cfg_valid = acc;
      cfg_data  = word;
      settle();
      chk_eq("cfg_ready", 32'(cfg_ready), 32'd1);
      chk_eq("in_ready_in_cfg", 32'(in_ready), 32'd0);
      step();
      if (acc) begin
        is_bias = ((idx % (NI + 1)) == NI);
        exp_cnn = 32'(idx / (NI + 1));
        chk_eq("n_weight_valid", 32'(n_weight_valid), 32'(!is_bias));
        chk_eq("n_bias_valid", 32'(n_bias_valid), 32'(is_bias));
        if (is_bias) begin
          chk_eq("n_bias", n_bias, word);
        end else begin
          chk_eq("n_weight", n_weight, word);
        end
        idx++;
      end else begin
        chk_eq("n_weight_valid_gap", 32'(n_weight_valid), 32'd0);
        chk_eq("n_bias_valid_gap", 32'(n_bias_valid), 32'd0);
      end
      chk_eq("config_neuron_num", config_neuron_num, exp_cnn);
    end
    chk_eq("cfg_guard", 32'(idx), 32'(total));
    cfg_valid = 1'b0;
    settle();
    chk_eq("busy_cfg_done", 32'(busy), 32'd0);
    chk_eq("cfg_ready_done", 32'(cfg_ready), 32'd0);
  endtask

  // One frame: NI activations, neuron response after 'delay' wait cycles
  // (resp 0 all valid, 1 partial, 2 none), then drain in neuron order.
  task automatic do_frame(input int gap_mode, input int delay, input int resp,
                          input int rdy_mode, input bit fixed_out, input bit rst_in_drain);
    logic [DW-1:0]    d;
    logic [DW-1:0]    exp_q[$];
    logic [DW-1:0]    w;
    logic [NN*DW-1:0] outv;
    bit               pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int               idx;
    int               guard;
    int               k;
    bit               acc;
    bit               r;
    idx   = 0;
    guard = 0;
    while (idx < NI && guard < 1000) begin
      guard++;
      case (gap_mode)
        0:       acc = 1'b1;
        1:       acc = ((guard % 2) == 1);
        default: acc = (idx == 0) || ($urandom_range(2) != 0);
      endcase
      d = (gap_mode == 1) ? 16'h0100 : 16'($urandom);
      in_valid = acc;
      in_data  = d;
      settle();
      chk_eq("in_ready_stream", 32'(in_ready), 32'd1);
      chk_eq("busy_stream", 32'(busy), 32'(idx != 0));
      step();
      chk_eq("n_input_valid", 32'(n_input_valid), 32'(acc));
      if (acc) begin
        chk_eq("n_input", 32'(n_input), 32'(d));
        idx++;
      end
    end
    chk_eq("frame_guard", 32'(idx), 32'(NI));
    in_valid = 1'b1;
    in_data  = 16'hffff;
    settle();
    chk_eq("in_ready_after_frame", 32'(in_ready), 32'd0);
    if (resp == 2) begin
      in_valid = 1'b0;
      for (int c = 1; c <= MW; c++) begin
        step();
        chk_eq("busy_timeout", 32'(busy), 32'(c < MW));
        chk_eq("err_timeout", 32'(err_timeout), 32'((c == MW) || exp_err_timeout));
        chk_eq("out_valid_timeout", 32'(out_valid), 32'd0);
      end
      exp_err_timeout = 1'b1;
      return;
    end
    for (int c = 0; c < delay; c++) begin
      step();
      chk_eq("busy_wait", 32'(busy), 32'd1);
      chk_eq("out_valid_wait", 32'(out_valid), 32'd0);
      chk_eq("n_input_valid_wait", 32'(n_input_valid), 32'd0);
      chk_eq("err_timeout_wait", 32'(err_timeout), 32'(exp_err_timeout));
    end
    in_valid = 1'b0;
    for (int n = 0; n < NN; n++) begin
      w = fixed_out ? 16'(17 * (n + 1)) : 16'($urandom);
      exp_q.push_back(w);
      outv[n*DW +: DW] = w;
    end
    n_output = outv;
    n_output_valid = (resp == 0) ? {NN{1'b1}} : NN'($urandom_range(2**NN - 2, 1));
    step();
    n_output_valid = '0;
    n_output       = NN*DW'({$urandom, $urandom});
    if (resp == 1) begin
      exp_err_sync = 1'b1;
    end
    k     = 0;
    guard = 0;
    while (k < NN && guard < 200) begin
      if (rst_in_drain && k == 1) begin
        pulse_reset();
        return;
      end
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = pat[guard % 5];
        default: r = 1'($urandom_range(1));
      endcase
      out_ready = r;
      settle();
      chk_eq("out_valid", 32'(out_valid), 32'd1);
      chk_eq("out_data", 32'(out_data), 32'(exp_q[k]));
      chk_eq("out_last", 32'(out_last), 32'(k == NN - 1));
      chk_eq("err_sync", 32'(err_sync), 32'(exp_err_sync));
      chk_eq("in_ready_drain", 32'(in_ready), 32'd0);
      step();
      guard++;
      if (r) begin
        k++;
      end
    end
    chk_eq("drain_guard", 32'(k), 32'(NN));
    out_ready = 1'b0;
    settle();
    chk_eq("out_valid_done", 32'(out_valid), 32'd0);
    chk_eq("busy_done", 32'(busy), 32'd0);
    chk_eq("err_sync_done", 32'(err_sync), 32'(exp_err_sync));
    chk_eq("err_timeout_done", 32'(err_timeout), 32'(exp_err_timeout));
  endtask

  initial begin
    rst             = 1'b1;
    cfg_start       = 1'b0;
    cfg_data        = 32'd0;
    cfg_valid       = 1'b0;
    in_data         = '0;
    in_valid        = 1'b0;
    n_output        = '0;
    n_output_valid  = '0;
    out_ready       = 1'b0;
    exp_err_sync    = 1'b0;
    exp_err_timeout = 1'b0;
    exp_cnn         = 32'd0;
    repeat (2) step();
    rst = 1'b0;
    settle();
    chk_reset_state();

    do_config(1'b1, 0, 1'b0, -1);
    do_frame(1, 5, 0, 0, 1'b1, 1'b0);
    do_frame(0, 5, 0, 1, 1'b1, 1'b0);
    do_frame(2, 2, 1, 0, 1'b0, 1'b0);
    do_frame(0, 0, 2, 0, 1'b0, 1'b0);
    do_config(1'b0, 0, 1'b0, 2);
    do_frame(0, 3, 0, 0, 1'b0, 1'b1);
    do_config(1'b0, 30, 1'b1, -1);

    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(3) == 0) begin
        do_config(1'b0, $urandom_range(50), 1'($urandom_range(1)), -1);
      end else begin
        do_frame(2, $urandom_range(MW - 1), ($urandom_range(9) == 0) ? 2 : ($urandom_range(4) == 0 ? 1 : 0),
                 2, 1'b0, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
